// File: rtl/tcam_spike_sched.sv
// Round-robin spike scheduler in front of a TCAM: arbitrates lookups, tracks
// their source through a fixed-latency tag pipe, and sequences two-write entry programming.
module tcam_spike_sched #(
  parameter int NREQ         = 4,
  parameter int ID_Width     = 4,
  parameter int Weight_Width = 4,
  parameter int AddressSize  = 4,
  parameter int Bits         = 8,
  parameter int LOOKUP_LAT   = 1,
  localparam int SW          = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*ID_Width-1:0] req_id,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  input  logic [AddressSize-1:0]   cfg_addr,
  input  logic [Bits-1:0]          cfg_data,
  input  logic [Bits-1:0]          cfg_care,
  input  logic                     cfg_vb,
  output logic                     CS,
  output logic                     WR,
  output logic                     DCS,
  output logic                     VBE,
  output logic                     VBI,
  output logic [Bits-1:0]          Data_In,
  output logic [Bits-1:0]          Mask_In,
  output logic [AddressSize-1:0]   Addr_In,
  output logic [ID_Width-1:0]      PacketID_In,
  input  logic [ID_Width-1:0]      DstID_Out,
  input  logic [Weight_Width-1:0]  Weight_Out,
  output logic                     res_valid,
  output logic [SW-1:0]            res_src,
  output logic [ID_Width-1:0]      res_dst,
  output logic [Weight_Width-1:0]  res_weight
);

  typedef enum logic [1:0] {IDLE, DRAIN, CFG_DATA, CFG_CARE} state_t;

  state_t                         state_q, state_d;
  logic [SW-1:0]                  ptr_q, ptr_d;
  logic [LOOKUP_LAT-1:0]          vld_pipe_q;
  logic [LOOKUP_LAT-1:0][SW-1:0]  tag_pipe_q;
  logic                           found, xfer, inflight;
  logic [SW-1:0]                  gnt_idx;

  assign inflight = |vld_pipe_q;

  // First valid requester at or after the pointer, wrapping.
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req_valid[(int'(ptr_q) + k) % NREQ]) begin
        found   = 1'b1;
        gnt_idx = SW'((int'(ptr_q) + k) % NREQ);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    xfer        = 1'b0;
    req_ready   = '0;
    cfg_ready   = 1'b0;
    CS          = 1'b0;
    WR          = 1'b0;
    DCS         = 1'b0;
    VBE         = 1'b0;
    VBI         = 1'b0;
    Data_In     = '0;
    Mask_In     = '0;
    Addr_In     = '0;
    PacketID_In = '0;
    case (state_q)
      IDLE: begin
        if (cfg_valid) begin
          state_d = inflight ? DRAIN : CFG_DATA;
        end else if (found) begin
          xfer               = 1'b1;
          req_ready[gnt_idx] = 1'b1;
          CS                 = 1'b1;
          PacketID_In        = req_id[int'(gnt_idx)*ID_Width +: ID_Width];
          ptr_d              = (int'(gnt_idx) == NREQ-1) ? '0 : gnt_idx + 1'b1;
        end
      end
      DRAIN: if (!inflight) state_d = CFG_DATA;
      CFG_DATA: begin
        CS      = 1'b1;
        WR      = 1'b1;
        DCS     = 1'b1;
        VBE     = 1'b1;
        VBI     = cfg_vb;
        Addr_In = cfg_addr;
        Data_In = cfg_data;
        Mask_In = '1;
        state_d = CFG_CARE;
      end
      CFG_CARE: begin
        CS        = 1'b1;
        WR        = 1'b1;
        VBE       = 1'b1;
        VBI       = cfg_vb;
        Addr_In   = cfg_addr;
        Data_In   = cfg_care;
        Mask_In   = '1;
        cfg_ready = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // The TCAM needs CS held while it resets; everything else is quiet.
    if (rst) begin
      xfer        = 1'b0;
      req_ready   = '0;
      cfg_ready   = 1'b0;
      CS          = 1'b1;
      WR          = 1'b0;
      DCS         = 1'b0;
      VBE         = 1'b0;
      VBI         = 1'b0;
      Data_In     = '0;
      Mask_In     = '0;
      Addr_In     = '0;
      PacketID_In = '0;
    end
  end

  always_comb begin
    res_valid  = vld_pipe_q[LOOKUP_LAT-1] && !rst;
    res_src    = res_valid ? tag_pipe_q[LOOKUP_LAT-1] : '0;
    res_dst    = res_valid ? DstID_Out : '0;
    res_weight = res_valid ? Weight_Out : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      vld_pipe_q <= '0;
      tag_pipe_q <= '0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      vld_pipe_q[0] <= xfer;
      tag_pipe_q[0] <= gnt_idx;
      for (int k = 1; k < LOOKUP_LAT; k++) begin
        vld_pipe_q[k] <= vld_pipe_q[k-1];
        tag_pipe_q[k] <= tag_pipe_q[k-1];
      end
    end
  end

endmodule

// File: tb/tb_tcam_spike_sched.sv
// Directed bench for tcam_spike_sched (default parameters, LOOKUP_LAT=1) with a
// one-cycle Mem model: DstID = PacketID ^ 4'hA, Weight = PacketID + 1.
module tb_tcam_spike_sched;

  typedef struct packed {
    logic        rst;
    logic [3:0]  rv;
    logic [15:0] rid;
    logic        cv;
    logic [3:0]  ca;
    logic [7:0]  cd;
    logic [7:0]  cc;
    logic        vb;
  } in_t;

  typedef struct packed {
    logic [3:0] rr;
    logic [4:0] ctl;   // {CS,WR,DCS,VBE,VBI}
    logic [7:0] data;
    logic [7:0] mask;
    logic [3:0] addr;
    logic [3:0] pid;
    logic       cfgr;
    logic       resv;
    logic [1:0] src;
    logic [3:0] dst;
    logic [3:0] w;
  } out_t;

  typedef struct packed {
    in_t  i;
    out_t o;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid, req_ready;
  logic [15:0] req_id;
  logic        cfg_valid, cfg_ready, cfg_vb;
  logic [3:0]  cfg_addr;
  logic [7:0]  cfg_data, cfg_care;
  logic        CS, WR, DCS, VBE, VBI;
  logic [7:0]  Data_In, Mask_In;
  logic [3:0]  Addr_In, PacketID_In;
  logic [3:0]  DstID_Out, Weight_Out;
  logic        res_valid;
  logic [1:0]  res_src;
  logic [3:0]  res_dst, res_weight;

  int checks = 0;
  int failures = 0;
  vec_t tv[$];

  always #5 clk = ~clk;

  tcam_spike_sched dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_id(req_id),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_care(cfg_care), .cfg_vb(cfg_vb),
    .CS(CS), .WR(WR), .DCS(DCS), .VBE(VBE), .VBI(VBI),
    .Data_In(Data_In), .Mask_In(Mask_In), .Addr_In(Addr_In), .PacketID_In(PacketID_In),
    .DstID_Out(DstID_Out), .Weight_Out(Weight_Out),
    .res_valid(res_valid), .res_src(res_src), .res_dst(res_dst), .res_weight(res_weight)
  );

  // Mem model: registered result of the ID presented last cycle.
  always_ff @(posedge clk) begin
    DstID_Out  <= PacketID_In ^ 4'hA;
    Weight_Out <= PacketID_In + 4'd1;
  end

  function automatic in_t I(logic r, logic [3:0] rv, logic [15:0] rid, logic cv,
                            logic [3:0] ca, logic [7:0] cd, logic [7:0] cc, logic vb);
    I = '{r, rv, rid, cv, ca, cd, cc, vb};
  endfunction

  function automatic out_t O(logic [3:0] rr, logic [4:0] ctl, logic [7:0] d, logic [7:0] m,
                             logic [3:0] a, logic [3:0] p, logic cr, logic rv,
                             logic [1:0] s, logic [3:0] dst, logic [3:0] w);
    O = '{rr, ctl, d, m, a, p, cr, rv, s, dst, w};
  endfunction

  task automatic drive(input in_t v);
    rst = v.rst; req_valid = v.rv; req_id = v.rid; cfg_valid = v.cv;
    cfg_addr = v.ca; cfg_data = v.cd; cfg_care = v.cc; cfg_vb = v.vb;
  endtask

  // Apply one cycle of inputs, compare at the falling edge, then advance.
  task automatic cycle(input string name, input in_t v, input out_t exp);
    out_t act;
    drive(v);
    @(negedge clk);
    act = '{req_ready, {CS, WR, DCS, VBE, VBI}, Data_In, Mask_In, Addr_In, PacketID_In,
            cfg_ready, res_valid, res_src, res_dst, res_weight};
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got rr=%b ctl=%b d=%h m=%h a=%h pid=%h cfgr=%b rv=%b src=%0d dst=%h w=%h, expected rr=%b ctl=%b d=%h m=%h a=%h pid=%h cfgr=%b rv=%b src=%0d dst=%h w=%h",
               name, act.rr, act.ctl, act.data, act.mask, act.addr, act.pid, act.cfgr, act.resv,
               act.src, act.dst, act.w, exp.rr, exp.ctl, exp.data, exp.mask, exp.addr, exp.pid,
               exp.cfgr, exp.resv, exp.src, exp.dst, exp.w);
    end
    @(posedge clk);
    #1;
  endtask

  localparam in_t  IZ = '0;
  localparam out_t OZ = '0;

  initial begin
    in_t  cf1, cf2, cf3, all4;
    cf1  = I(0, 4'h0, 16'h0, 1, 4'h0, 8'h00, 8'hFF, 1);
    cf2  = I(0, 4'b0001, 16'h0006, 1, 4'h5, 8'h3C, 8'hF0, 0);
    cf3  = I(0, 4'h0, 16'h0, 1, 4'h9, 8'h55, 8'hAA, 1);
    all4 = I(0, 4'hF, 16'h4321, 0, 0, 0, 0, 0);

    tv.push_back('{I(1, 0, 0, 0, 0, 0, 0, 0), O(0, 5'b10000, 0, 0, 0, 0, 0, 0, 0, 0, 0)});
    tv.push_back('{IZ, OZ});
    // program addr 0, data 00, care FF, vb 1
    tv.push_back('{cf1, OZ});
    tv.push_back('{cf1, O(0, 5'b11111, 8'h00, 8'hFF, 4'h0, 0, 0, 0, 0, 0, 0)});
    tv.push_back('{cf1, O(0, 5'b11011, 8'hFF, 8'hFF, 4'h0, 0, 1, 0, 0, 0, 0)});
    // all four requesting: round robin 0,1,2,3,0
    tv.push_back('{all4, O(4'b0001, 5'b10000, 0, 0, 0, 4'h1, 0, 0, 0, 0, 0)});
    tv.push_back('{all4, O(4'b0010, 5'b10000, 0, 0, 0, 4'h2, 0, 1, 0, 4'hB, 4'h2)});
    tv.push_back('{all4, O(4'b0100, 5'b10000, 0, 0, 0, 4'h3, 0, 1, 1, 4'h8, 4'h3)});
    tv.push_back('{all4, O(4'b1000, 5'b10000, 0, 0, 0, 4'h4, 0, 1, 2, 4'h9, 4'h4)});
    tv.push_back('{all4, O(4'b0001, 5'b10000, 0, 0, 0, 4'h1, 0, 1, 3, 4'hE, 4'h5)});
    // lone requester 2 with id 5
    tv.push_back('{I(0, 4'b0100, 16'h0500, 0, 0, 0, 0, 0), O(4'b0100, 5'b10000, 0, 0, 0, 4'h5, 0, 1, 0, 4'hB, 4'h2)});
    tv.push_back('{IZ, O(0, 0, 0, 0, 0, 0, 0, 1, 2, 4'hF, 4'h6)});
    // pointer at 3; then requester 0 idle, so 1 is next
    tv.push_back('{I(0, 4'b1010, 16'h7080, 0, 0, 0, 0, 0), O(4'b1000, 5'b10000, 0, 0, 0, 4'h7, 0, 0, 0, 0, 0)});
    tv.push_back('{I(0, 4'b0010, 16'h7080, 0, 0, 0, 0, 0), O(4'b0010, 5'b10000, 0, 0, 0, 4'h8, 0, 1, 3, 4'hD, 4'h8)});
    // cfg with a lookup in flight: blocked, drain, then program (vb=0)
    tv.push_back('{cf2, O(0, 0, 0, 0, 0, 0, 0, 1, 1, 4'h2, 4'h9)});
    tv.push_back('{cf2, OZ});
    tv.push_back('{cf2, O(0, 5'b11110, 8'h3C, 8'hFF, 4'h5, 0, 0, 0, 0, 0, 0)});
    tv.push_back('{cf2, O(0, 5'b11010, 8'hF0, 8'hFF, 4'h5, 0, 1, 0, 0, 0, 0)});
    tv.push_back('{I(0, 4'b0001, 16'h0006, 0, 0, 0, 0, 0), O(4'b0001, 5'b10000, 0, 0, 0, 4'h6, 0, 0, 0, 0, 0)});
    // reset lands in CFG_CARE: no cfg_ready, pointer back to 0
    tv.push_back('{cf3, O(0, 0, 0, 0, 0, 0, 0, 1, 0, 4'hC, 4'h7)});
    tv.push_back('{cf3, OZ});
    tv.push_back('{cf3, O(0, 5'b11111, 8'h55, 8'hFF, 4'h9, 0, 0, 0, 0, 0, 0)});
    tv.push_back('{I(1, 0, 0, 1, 4'h9, 8'h55, 8'hAA, 1), O(0, 5'b10000, 0, 0, 0, 0, 0, 0, 0, 0, 0)});
    tv.push_back('{IZ, OZ});
    tv.push_back('{all4, O(4'b0001, 5'b10000, 0, 0, 0, 4'h1, 0, 0, 0, 0, 0)});
    tv.push_back('{IZ, O(0, 0, 0, 0, 0, 0, 0, 1, 0, 4'hB, 4'h2)});
    // reset with a lookup in flight: the result is dropped
    tv.push_back('{I(0, 4'b0100, 16'h0500, 0, 0, 0, 0, 0), O(4'b0100, 5'b10000, 0, 0, 0, 4'h5, 0, 0, 0, 0, 0)});
    tv.push_back('{I(1, 0, 0, 0, 0, 0, 0, 0), O(0, 5'b10000, 0, 0, 0, 0, 0, 0, 0, 0, 0)});
    tv.push_back('{IZ, OZ});

    drive(IZ);
    #1;
    foreach (tv[n]) cycle($sformatf("vec%0d", n), tv[n].i, tv[n].o);

    // Sustained contention after reset: grants rotate, results trail by one cycle.
    for (int k = 0; k < 8; k++) begin
      out_t e;
      e = O(4'(1 << (k % 4)), 5'b10000, 0, 0, 0, 4'(k % 4 + 1), 0, 0, 0, 0, 0);
      if (k > 0) begin
        e.resv = 1'b1;
        e.src  = 2'((k - 1) % 4);
        e.dst  = 4'((k - 1) % 4 + 1) ^ 4'hA;
        e.w    = 4'((k - 1) % 4 + 2);
      end
      cycle($sformatf("rr%0d", k), all4, e);
    end
    cycle("rr_tail", IZ, O(0, 0, 0, 0, 0, 0, 0, 1, 3, 4'h4 ^ 4'hA, 4'h5));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
